// File: rtl/if_fetch.sv
// Instruction-fetch front end: issues one instruction-memory read per PC,
// presents the fetched {pc, inst, valid} to IF/ID, stalls the PC register while
// a read is outstanding, and re-drives a branch target that arrived mid-read.
module if_fetch #(
    parameter int AW = 32,
    parameter int IW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] pc_i,
    input  logic [5:0]    stall_i,
    input  logic          branch_flag_i,
    input  logic [AW-1:0] branch_target_i,
    output logic          mem_req_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic          mem_ack_i,
    input  logic [IW-1:0] mem_rdata_i,
    output logic          stall_req_o,
    output logic          pc_fix_o,
    output logic [AW-1:0] pc_fix_addr_o,
    output logic [AW-1:0] if_pc_o,
    output logic [IW-1:0] if_inst_o,
    output logic          if_valid_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        REDIR = 2'd3
    } state_t;

    state_t        state_q;
    logic          kill_q;
    logic          redir_q;
    logic [AW-1:0] redir_addr_q;
    logic          mem_req_q;
    logic [AW-1:0] mem_addr_q;
    logic [AW-1:0] skid_pc_q;
    logic [IW-1:0] skid_inst_q;
    logic          pc_fix_q;
    logic [AW-1:0] pc_fix_addr_q;
    logic [AW-1:0] if_pc_q;
    logic [IW-1:0] if_inst_q;
    logic          if_valid_q;

    // Only the PC and IF stall bits matter to fetch; the rest are unused here.
    logic unused_stall;
    assign unused_stall = ^stall_i[5:2];

    // The PC register may advance only in the IDLE cycle where a read is issued.
    assign stall_req_o = (state_q != IDLE);

    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;
    assign pc_fix_o      = pc_fix_q;
    assign pc_fix_addr_o = pc_fix_addr_q;
    assign if_pc_o       = if_pc_q;
    assign if_inst_o     = if_inst_q;
    assign if_valid_o    = if_valid_q;

    // Fetch FSM; the valid flush/clear defaults come first so a load later in the
    // block wins (a load never coincides with a branch, which always flushes).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            kill_q        <= 1'b0;
            redir_q       <= 1'b0;
            redir_addr_q  <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            skid_pc_q     <= '0;
            skid_inst_q   <= '0;
            pc_fix_q      <= 1'b0;
            pc_fix_addr_q <= '0;
            if_pc_q       <= '0;
            if_inst_q     <= '0;
            if_valid_q    <= 1'b0;
        end else begin
            if (branch_flag_i || !stall_i[1]) begin
                if_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (!stall_i[1]) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc_i;
                        kill_q     <= branch_flag_i;
                        state_q    <= WAIT;
                    end
                end

                WAIT: begin
                    if (branch_flag_i) begin
                        kill_q       <= 1'b1;
                        redir_q      <= 1'b1;
                        redir_addr_q <= branch_target_i;
                    end
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        if (kill_q || branch_flag_i) begin
                            kill_q <= 1'b0;
                            if (redir_q || branch_flag_i) begin
                                pc_fix_q      <= 1'b1;
                                pc_fix_addr_q <= branch_flag_i ? branch_target_i : redir_addr_q;
                                state_q       <= REDIR;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else if (!stall_i[1]) begin
                            if_pc_q    <= mem_addr_q;
                            if_inst_q  <= mem_rdata_i;
                            if_valid_q <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            skid_pc_q   <= mem_addr_q;
                            skid_inst_q <= mem_rdata_i;
                            state_q     <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    if (branch_flag_i) begin
                        state_q <= IDLE;
                    end else if (!stall_i[1]) begin
                        if_pc_q    <= skid_pc_q;
                        if_inst_q  <= skid_inst_q;
                        if_valid_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end

                REDIR: begin
                    if (!stall_i[0]) begin
                        pc_fix_q <= 1'b0;
                        redir_q  <= 1'b0;
                        state_q  <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: steady fetch, wait states, branch redirect,
// IF stall with skid buffer, IDLE-cycle branch kill, and mid-read reset.
module tb_if_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] pcIn;
    logic [5:0]  stallIn;
    logic        branchFlag;
    logic [31:0] branchTarget;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memRdata;
    logic        stallReq;
    logic        pcFix;
    logic [31:0] pcFixAddr;
    logic [31:0] ifPc;
    logic [31:0] ifInst;
    logic        ifValid;

    int assertCount = 0;
    int failCount   = 0;

    if_fetch #(.AW(32), .IW(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_i            (pcIn),
        .stall_i         (stallIn),
        .branch_flag_i   (branchFlag),
        .branch_target_i (branchTarget),
        .mem_req_o       (memReq),
        .mem_addr_o      (memAddr),
        .mem_ack_i       (memAck),
        .mem_rdata_i     (memRdata),
        .stall_req_o     (stallReq),
        .pc_fix_o        (pcFix),
        .pc_fix_addr_o   (pcFixAddr),
        .if_pc_o         (ifPc),
        .if_inst_o       (ifInst),
        .if_valid_o      (ifValid)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and count it
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full fetch from IDLE: issue pc, hold for 'waits' cycles, then ack with data
    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] data, input int waits, input string tag);
        pcIn   = pc;
        memAck = 1'b0;
        tick();
        checkOutput({tag, " req"},      {31'd0, memReq},   32'd1);
        checkOutput({tag, " addr"},     memAddr,           pc);
        checkOutput({tag, " stallreq"}, {31'd0, stallReq}, 32'd1);
        for (int i = 0; i < waits; i++) begin
            tick();
            checkOutput({tag, " addr held"},  memAddr,           pc);
            checkOutput({tag, " stall held"}, {31'd0, stallReq}, 32'd1);
        end
        memAck   = 1'b1;
        memRdata = data;
        tick();
        memAck = 1'b0;
        checkOutput({tag, " if_pc"},     ifPc,              pc);
        checkOutput({tag, " if_inst"},   ifInst,            data);
        checkOutput({tag, " if_valid"},  {31'd0, ifValid},  32'd1);
        checkOutput({tag, " req drop"},  {31'd0, memReq},   32'd0);
        checkOutput({tag, " stall rel"}, {31'd0, stallReq}, 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        pcIn         = '0;
        stallIn      = '0;
        branchFlag   = 1'b0;
        branchTarget = '0;
        memAck       = 1'b0;
        memRdata     = '0;

        // Reset state
        tick();
        tick();
        checkOutput("rst req",      {31'd0, memReq},   32'd0);
        checkOutput("rst addr",     memAddr,           32'd0);
        checkOutput("rst stallreq", {31'd0, stallReq}, 32'd0);
        checkOutput("rst pcfix",    {31'd0, pcFix},    32'd0);
        checkOutput("rst valid",    {31'd0, ifValid},  32'd0);
        checkOutput("rst if_pc",    ifPc,              32'd0);
        rst_n = 1'b1;

        // T2: back-to-back fetches with zero wait cycles
        applyStimulus(32'h0, 32'hAAAA_0000, 0, "T2 pc0");
        applyStimulus(32'h4, 32'hAAAA_0004, 0, "T2 pc4");
        applyStimulus(32'h8, 32'hAAAA_0008, 0, "T2 pc8");

        // T3: three wait cycles, address and stall request held throughout
        applyStimulus(32'hC, 32'hBBBB_000C, 3, "T3 pcC");

        // Valid drops in the following issue cycle when nothing new loads
        pcIn = 32'h10;
        tick();
        checkOutput("valid clear", {31'd0, ifValid}, 32'd0);
        memAck   = 1'b1;
        memRdata = 32'hCCCC_0010;
        tick();
        memAck = 1'b0;
        checkOutput("pc10 if_pc", ifPc, 32'h10);

        // T5: IF stalled at the ack of 0x4 -> skid buffer, if_* keep 0x0
        applyStimulus(32'h0, 32'hDDDD_0000, 0, "T5 pc0");
        pcIn = 32'h4;
        tick();
        memAck   = 1'b1;
        memRdata = 32'hDDDD_0004;
        stallIn  = 6'b000010;
        tick();
        memAck = 1'b0;
        checkOutput("T5 hold if_pc",    ifPc,              32'h0);
        checkOutput("T5 hold if_inst",  ifInst,            32'hDDDD_0000);
        checkOutput("T5 hold stallreq", {31'd0, stallReq}, 32'd1);
        tick();
        checkOutput("T5 hold2 if_pc",   ifPc,              32'h0);
        stallIn = 6'b000000;
        tick();
        checkOutput("T5 rel if_pc",     ifPc,              32'h4);
        checkOutput("T5 rel if_inst",   ifInst,            32'hDDDD_0004);
        checkOutput("T5 rel valid",     {31'd0, ifValid},  32'd1);
        checkOutput("T5 rel stallreq",  {31'd0, stallReq}, 32'd0);

        // T4: branch to 0x100 while waiting on 0x8
        pcIn = 32'h8;
        tick();
        branchFlag   = 1'b1;
        branchTarget = 32'h100;
        tick();
        branchFlag = 1'b0;
        checkOutput("T4 valid flush", {31'd0, ifValid}, 32'd0);
        checkOutput("T4 addr held",   memAddr,          32'h8);
        memAck   = 1'b1;
        memRdata = 32'hEEEE_0008;
        stallIn  = 6'b000001;
        tick();
        memAck = 1'b0;
        checkOutput("T4 pcfix",      {31'd0, pcFix},    32'd1);
        checkOutput("T4 pcfix addr", pcFixAddr,         32'h100);
        checkOutput("T4 dropped pc", ifPc,              32'h4);
        checkOutput("T4 valid",      {31'd0, ifValid},  32'd0);
        checkOutput("T4 stallreq",   {31'd0, stallReq}, 32'd1);
        tick();
        checkOutput("T4 pcfix held", {31'd0, pcFix},    32'd1);
        stallIn = 6'b000000;
        tick();
        checkOutput("T4 pcfix rel",  {31'd0, pcFix},    32'd0);
        applyStimulus(32'h100, 32'hEEEE_0100, 0, "T4 pc100");

        // Branch in the same cycle as the ack also counts as killed
        pcIn = 32'h104;
        tick();
        memAck       = 1'b1;
        memRdata     = 32'h1234_5678;
        branchFlag   = 1'b1;
        branchTarget = 32'h180;
        tick();
        memAck     = 1'b0;
        branchFlag = 1'b0;
        checkOutput("same ack pcfix", {31'd0, pcFix}, 32'd1);
        checkOutput("same ack addr",  pcFixAddr,      32'h180);
        checkOutput("same ack if_pc", ifPc,           32'h100);
        tick();
        checkOutput("same ack rel",   {31'd0, pcFix}, 32'd0);

        // T6: branch in the IDLE issue cycle kills that read without pc_fix
        pcIn         = 32'h200;
        branchFlag   = 1'b1;
        branchTarget = 32'h300;
        tick();
        branchFlag = 1'b0;
        checkOutput("T6 req",   {31'd0, memReq},  32'd1);
        checkOutput("T6 addr",  memAddr,          32'h200);
        checkOutput("T6 valid", {31'd0, ifValid}, 32'd0);
        memAck   = 1'b1;
        memRdata = 32'hFFFF_0200;
        tick();
        memAck = 1'b0;
        checkOutput("T6 if_pc",    ifPc,              32'h100);
        checkOutput("T6 valid2",   {31'd0, ifValid},  32'd0);
        checkOutput("T6 no pcfix", {31'd0, pcFix},    32'd0);
        checkOutput("T6 stallreq", {31'd0, stallReq}, 32'd0);

        // Ack outside WAIT is ignored (IF stalled, so no issue either)
        stallIn  = 6'b000010;
        memAck   = 1'b1;
        memRdata = 32'h0BAD_0BAD;
        pcIn     = 32'h300;
        tick();
        memAck  = 1'b0;
        checkOutput("stray ack if_pc", ifPc,             32'h100);
        checkOutput("stray ack req",   {31'd0, memReq},  32'd0);
        stallIn = 6'b000000;

        // T1: asynchronous reset in the middle of a read
        tick();
        checkOutput("T1 in wait", {31'd0, memReq}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("T1 req",      {31'd0, memReq},   32'd0);
        checkOutput("T1 valid",    {31'd0, ifValid},  32'd0);
        checkOutput("T1 stallreq", {31'd0, stallReq}, 32'd0);
        tick();
        rst_n = 1'b1;
        applyStimulus(32'h40, 32'h5555_0040, 1, "T1 recover");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Global time limit so the run always terminates
    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no finish, expected finish before 100000 ns");
        failCount++;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
